alu_exec_unit: RTL

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder. It performs the requested operation on two operands and returns a registered result with flags. Logic and add/sub ops complete in one cycle. Multiply and divide run as iterative WIDTH-cycle sequences that write a HI/LO pair. The pipeline hazard logic stalls on `busy`.

---
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/alu_exec_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the issue logic and the execute-stage ALU.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, ctrl, a, b,
    input  result, zero, overflow, hi, lo, busy, done
  );

  modport slave (
    input  start, ctrl, a, b,
    output result, zero, overflow, hi, lo, busy, done
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/compare ops plus iterative
// WIDTH-cycle shift-add multiply and restoring divide writing a HI/LO pair.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_exec_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic             is_div_q, is_div_d, pneg_q, pneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

  logic [WIDTH-1:0]   sum_s, diff_s, alu_res_s;
  logic               alu_ovf_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH:0]     mul_sum_s, div_sh_s;
  logic [WIDTH-1:0]   div_diff_s, step_hi_s, step_lo_s, quo_fix_s, rem_fix_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  // Single-cycle datapath: result and signed overflow for the requested code.
  always_comb begin
    sum_s     = bus.a + bus.b;
    diff_s    = bus.a - bus.b;
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (bus.ctrl)
      4'b0000: alu_res_s = bus.a & bus.b;
      4'b0001: alu_res_s = bus.a | bus.b;
      4'b0010: alu_res_s = sum_s;
      4'b0011: alu_res_s = diff_s;
      4'b0100: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b0101: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'b0111: alu_res_s = ~(bus.a | bus.b);
      4'b1010: begin
        alu_res_s = sum_s;
        alu_ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b1011: begin
        alu_res_s = diff_s;
        alu_ovf_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // Operand magnitudes for mul/div; ctrl[1] selects the signed variants.
  always_comb begin
    a_neg_s = bus.ctrl[1] & bus.a[WIDTH-1];
    b_neg_s = bus.ctrl[1] & bus.b[WIDTH-1];
    mag_a_s = a_neg_s ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    mag_b_s = b_neg_s ? ({WIDTH{1'b0}} - bus.b) : bus.b;
  end

  // One mul/div iteration on the accumulator pair plus the final sign fix-up.
  always_comb begin
    mul_sum_s  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_s   = div_sh_s >= {1'b0, opnd_q};
    div_diff_s = div_sh_s[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi_s = div_ge_s ? div_diff_s : div_sh_s[WIDTH-1:0];
      step_lo_s = {acc_lo_q[WIDTH-2:0], div_ge_s};
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
    end
    prod_s     = {step_hi_s, step_lo_s};
    prod_fix_s = pneg_q ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    // With a zero divisor every trial subtract succeeds, so the remainder
    // ends up as |a| and the remainder sign fix-up restores the raw a.
    quo_fix_s  = dz_q ? {WIDTH{1'b1}} : (pneg_q ? ({WIDTH{1'b0}} - step_lo_s) : step_lo_s);
    rem_fix_s  = rneg_q ? ({WIDTH{1'b0}} - step_hi_s) : step_hi_s;
  end

  // Next-state and output-register logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    pneg_d   = pneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.ctrl[3:2] == 2'b11) begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH - 1);
            ovf_d    = 1'b0;
            is_div_d = bus.ctrl[0];
            pneg_d   = a_neg_s ^ b_neg_s;
            rneg_d   = a_neg_s;
            dz_d     = bus.ctrl[0] && (bus.b == {WIDTH{1'b0}});
            acc_hi_d = {WIDTH{1'b0}};
            acc_lo_d = bus.ctrl[0] ? mag_a_s : mag_b_s;
            opnd_d   = bus.ctrl[0] ? mag_b_s : mag_a_s;
          end else begin
            result_d = alu_res_s;
            zero_d   = (alu_res_s == {WIDTH{1'b0}});
            ovf_d    = alu_ovf_s;
            done_d   = 1'b1;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      RUN: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = IDLE;
          done_d  = 1'b1;
          hi_d    = is_div_q ? rem_fix_s : prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d    = is_div_q ? quo_fix_s : prod_fix_s[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      pneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      pneg_q   <= pneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
endmodule
